// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - 1-to-2 stream demultiplexer with packet lock and per-branch 2-entry FIFOs
//
// Purpose:
//   Steers each input beat to branch 0 or 1. The branch is chosen by in_sel on
//   the first beat of a packet and held until the beat carrying in_last, so a
//   packet never straddles branches. Each branch buffers beats in a 2-entry
//   FIFO whose head entry drives the branch outputs directly from flops.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_data/in_last/in_sel     input payload, end-of-packet flag, branch select
//   out0_valid/out0_ready      branch-0 handshake
//   out0_data/out0_last        branch-0 payload and end-of-packet flag
//   out1_*                     same as out0_*, for branch 1
//   beats0/beats1              delivered-beat counters, wrap modulo 2^CNT_W

module demux2_stream #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [DW-1:0]    out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [DW-1:0]    out1_data,
  output logic             out1_last,
  output logic [CNT_W-1:0] beats0,
  output logic [CNT_W-1:0] beats1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   route;
  logic   accept;

  // Per-branch FIFO: head is the entry presented on the outputs, tail is the
  // second entry. Each word is {last, data}.
  logic [DW:0]    head  [2];
  logic [DW:0]    tail  [2];
  logic [1:0]     count [2];
  logic [CNT_W-1:0] beats [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_rdy;
  logic [1:0] full;
  logic [DW:0] beat_in;

  assign beat_in = {in_last, in_data};
  assign out_rdy = {out1_ready, out0_ready};

  assign full[0] = (count[0] == 2'd2);
  assign full[1] = (count[1] == 2'd2);

  // Readiness looks only at occupancy, never at the consumer ready, so a full
  // FIFO blocks input even on a cycle where it is being popped. Gating with
  // rst_n keeps in_ready low for the whole reset interval.
  assign in_ready = rst_n && !full[route];
  assign accept   = in_valid && in_ready;

  assign push[0] = accept && !route;
  assign push[1] = accept &&  route;
  assign pop[0]  = (count[0] != 2'd0) && out_rdy[0];
  assign pop[1]  = (count[1] != 2'd0) && out_rdy[1];

  // Routing FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Routing FSM: next state
  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        IDLE:         if (!in_last) state_nx = in_sel ? LOCK1 : LOCK0;
        LOCK0, LOCK1: if (in_last)  state_nx = IDLE;
        default:      state_nx = IDLE;
      endcase
    end
  end

  // Routing FSM: outputs
  always_comb begin
    route = 1'b0;
    case (state)
      IDLE:    route = in_sel;
      LOCK0:   route = 1'b0;
      LOCK1:   route = 1'b1;
      default: route = 1'b0;
    endcase
  end

  // FIFOs and delivered-beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        head[b]  <= '0;
        tail[b]  <= '0;
        count[b] <= 2'd0;
        beats[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        case ({push[b], pop[b]})
          2'b10: begin
            if (count[b] == 2'd0) head[b] <= beat_in;
            else                  tail[b] <= beat_in;
            count[b] <= count[b] + 2'd1;
          end
          2'b01: begin
            head[b]  <= tail[b];
            count[b] <= count[b] - 2'd1;
          end
          2'b11: begin
            // Occupancy unchanged. With one entry the new beat replaces the
            // departing head; with two it queues behind the promoted tail.
            if (count[b] == 2'd1) begin
              head[b] <= beat_in;
            end else begin
              head[b] <= tail[b];
              tail[b] <= beat_in;
            end
          end
          default: ;
        endcase
        if (pop[b]) beats[b] <= beats[b] + 1'b1;
      end
    end
  end

  assign out0_valid = (count[0] != 2'd0);
  assign out0_data  = head[0][DW-1:0];
  assign out0_last  = head[0][DW];
  assign out1_valid = (count[1] != 2'd0);
  assign out1_data  = head[1][DW-1:0];
  assign out1_last  = head[1][DW];
  assign beats0     = beats[0];
  assign beats1     = beats[1];

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - randomized and directed bench for demux2_stream against a queue model

module tb_demux2_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_sel = 1'b0;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;

  logic        in_ready, out0_valid, out0_last, out1_valid, out1_last;
  logic [7:0]  out0_data, out1_data;
  logic [15:0] beats0, beats1;

  logic        w_in_ready, w_out0_valid, w_out0_last, w_out1_valid, w_out1_last;
  logic [7:0]  w_out0_data, w_out1_data;
  logic [3:0]  w_beats0, w_beats1;

  always #5 clk = ~clk;

  demux2_stream #(.DW(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .out1_last(out1_last),
    .beats0(beats0), .beats1(beats1)
  );

  demux2_stream #(.DW(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out0_valid(w_out0_valid), .out0_ready(out0_ready),
    .out0_data(w_out0_data), .out0_last(w_out0_last),
    .out1_valid(w_out1_valid), .out1_ready(out1_ready),
    .out1_data(w_out1_data), .out1_last(w_out1_last),
    .beats0(w_beats0), .beats1(w_beats1)
  );

  // Reference model: each branch is the ordered list of {last,data} beats
  // accepted but not yet delivered; a packet is either open (locked to a
  // branch) or not.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         in_pkt = 1'b0;
  bit         pkt_br = 1'b0;
  int         cnt0 = 0;
  int         cnt1 = 0;
  bit         last_acc = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    in_pkt = 1'b0;
    pkt_br = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  // One clock cycle: compare every output with the model, then advance the
  // model by whatever transfers the model says happen at the coming edge.
  task automatic step();
    bit r, rdy, acc, p0, p1;
    #1;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out0_valid", out0_valid, 0);
      check("rst_out0_data", out0_data, 0);
      check("rst_out0_last", out0_last, 0);
      check("rst_out1_valid", out1_valid, 0);
      check("rst_out1_data", out1_data, 0);
      check("rst_out1_last", out1_last, 0);
      check("rst_beats0", beats0, 0);
      check("rst_beats1", beats1, 0);
      check("rst_w_beats0", w_beats0, 0);
      last_acc = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    r   = in_pkt ? pkt_br : in_sel;
    rdy = (r ? q1.size() : q0.size()) < 2;
    check("in_ready", in_ready, rdy);
    check("w_in_ready", w_in_ready, rdy);
    check("out0_valid", out0_valid, q0.size() != 0);
    check("out1_valid", out1_valid, q1.size() != 0);
    check("w_out0_valid", w_out0_valid, q0.size() != 0);
    if (q0.size() != 0) begin
      check("out0_data", out0_data, q0[0][7:0]);
      check("out0_last", out0_last, q0[0][8]);
      check("w_out0_data", w_out0_data, q0[0][7:0]);
    end
    if (q1.size() != 0) begin
      check("out1_data", out1_data, q1[0][7:0]);
      check("out1_last", out1_last, q1[0][8]);
      check("w_out1_last", w_out1_last, q1[0][8]);
    end
    check("beats0", beats0, cnt0 % 65536);
    check("beats1", beats1, cnt1 % 65536);
    check("w_beats0", w_beats0, cnt0 % 16);
    check("w_beats1", w_beats1, cnt1 % 16);
    acc = in_valid && rdy;
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); cnt0++; end
    if (p1) begin void'(q1.pop_front()); cnt1++; end
    if (acc) begin
      if (r) q1.push_back({in_last, in_data});
      else   q0.push_back({in_last, in_data});
      if (!in_pkt && !in_last) begin
        in_pkt = 1'b1;
        pkt_br = in_sel;
      end else if (in_pkt && in_last) begin
        in_pkt = 1'b0;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    check("send_accepted", last_acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int n, sent, cyc, base;

    // Reset held with random inputs
    @(posedge clk);
    #1;
    repeat (5) begin
      in_valid   = $urandom_range(0, 1);
      in_data    = 8'($urandom);
      in_last    = $urandom_range(0, 1);
      in_sel     = $urandom_range(0, 1);
      out0_ready = $urandom_range(0, 1);
      out1_ready = $urandom_range(0, 1);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    model_reset();

    // Single beats
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    idle(3);
    check("single_beats0", beats0, 1);
    check("single_beats1", beats1, 1);

    // Packet lock: in_sel changes after the first beat but is ignored
    send(8'hA0, 1'b0, 1'b0);
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b1, 1'b0);
    send(8'hA3, 1'b1, 1'b1);
    idle(3);
    check("lock_beats0", beats0, 5);
    check("lock_beats1", beats1, 1);

    // Backpressure on branch 0
    out0_ready = 1'b0;
    send(8'hB0, 1'b0, 1'b1);
    send(8'hB1, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hB2;
    in_sel   = 1'b0;
    in_last  = 1'b1;
    check("bp_full_blocks", in_ready, 0);
    repeat (3) step();
    check("bp_still_blocked", in_ready, 0);
    check("bp_head_held", out0_data, 8'hB0);
    out0_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    check("bp_third_after_pop", n, 2);
    idle(4);
    check("bp_beats0", beats0, 8);

    // Throughput on branch 1
    out1_ready = 1'b1;
    in_sel  = 1'b1;
    in_last = 1'b1;
    base = cnt1;
    sent = 0;
    cyc  = 0;
    while ((cnt1 - base) < 100 && cyc < 300) begin
      in_valid = (sent < 100);
      in_data  = 8'($urandom);
      step();
      if (last_acc) sent++;
      cyc++;
    end
    check("tput_cycles", cyc, 101);
    check("tput_beats1", beats1, 101);
    idle(2);

    // Randomized traffic, including in_sel changes while stalled
    repeat (400) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      in_last    = ($urandom_range(0, 2) == 0);
      in_sel     = $urandom_range(0, 1);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_last    = 1'b1;
    send(8'h5A, 1'b0, 1'b1);
    idle(4);

    // Asynchronous reset mid-packet with two beats buffered on branch 0
    out0_ready = 1'b0;
    send(8'hC0, 1'b0, 1'b0);
    send(8'hC1, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_valid", out0_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out0_valid", out0_valid, 0);
    check("async_out0_data", out0_data, 0);
    check("async_in_ready", in_ready, 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    // A locked FSM would steer this onto branch 0
    send(8'hD1, 1'b1, 1'b1);
    idle(3);
    check("post_rst_beats1", beats1, 1);
    check("post_rst_beats0", beats0, 0);

    // Counter wrap on the 4-bit instance
    repeat (17) send(8'($urandom), 1'b0, 1'b1);
    idle(3);
    check("wrap_beats0_16", beats0, 17);
    check("wrap_beats0_4", w_beats0, 1);
    check("wrap_beats1_4", w_beats1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
